// File: rtl/alu_seq_if.sv
// Switch/button inputs and result/status outputs of the sequential pushbutton ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sw;
  logic             pb1;
  logic             pb2;
  logic             pb3;
  logic [WIDTH-1:0] result;
  logic [3:0]       m_3;
  logic [3:0]       flags;
  logic             busy;
  logic             done;

  modport master (
    output sw, pb1, pb2, pb3,
    input  result, m_3, flags, busy, done
  );

  modport slave (
    input  sw, pb1, pb2, pb3,
    output result, m_3, flags, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential pushbutton ALU: synchronised, edge-detected buttons load A/B or execute an opcode.
// Define ALU_SEQ_MUL_EN to build the WIDTH-cycle shift-add multiplier for opcode 111.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);

  logic [2:0] pb_raw;
  logic [2:0] ev;

  assign pb_raw = {bus.pb3, bus.pb2, bus.pb1};

  // Two sync flops, one edge-history flop, and a registered pulse so evN lands two cycles after the first sample.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic sync1_reg;
      logic sync2_reg;
      logic prev_reg;
      logic ev_reg;

      always_ff @(posedge clk) begin
        if (!rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          prev_reg  <= 1'b0;
          ev_reg    <= 1'b0;
        end else begin
          sync1_reg <= pb_raw[gi];
          sync2_reg <= sync1_reg;
          prev_reg  <= sync2_reg;
          ev_reg    <= sync2_reg & ~prev_reg;
        end
      end

      assign ev[gi] = ev_reg;
    end
  endgenerate

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [0:0] {IDLE, MUL} state_t;
`else
  typedef enum logic [0:0] {IDLE} state_t;
`endif

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] result_reg;
  logic [3:0]       flags_reg;
  logic [3:0]       m3_reg;
  logic             done_reg;

  logic [2:0]       op_sel;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] op_res;
  logic             op_c;
  logic             op_v;
  logic             op_z;
  logic             op_n;

  assign op_sel = ev[2] ? bus.sw[2:0] : op_reg;

  always_comb begin
    sum_ext = {1'b0, a_reg} + {1'b0, b_reg};
    diff    = a_reg - b_reg;
    op_res  = '0;
    op_c    = 1'b0;
    op_v    = 1'b0;
    case (op_sel)
      3'b001: begin
        op_res = sum_ext[WIDTH-1:0];
        op_c   = sum_ext[WIDTH];
        op_v   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (op_res[WIDTH-1] != a_reg[WIDTH-1]);
      end
      3'b010: begin
        op_res = diff;
        op_c   = a_reg < b_reg;
        op_v   = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (op_res[WIDTH-1] != a_reg[WIDTH-1]);
      end
      3'b100:  op_res = a_reg & b_reg;
      3'b101:  op_res = a_reg | b_reg;
      3'b110:  op_res = a_reg ^ b_reg;
      3'b011:  op_res = ~a_reg;
      default: op_res = '0;
    endcase
  end

  assign op_z = (op_res == '0);
  assign op_n = op_res[WIDTH-1];

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] prod_reg;
  logic [5:0]         cnt_reg;
  logic               busy_reg;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_next;

  // Upper half accumulates A when the current multiplier bit is set, then the pair shifts right.
  assign mul_sum   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + (prod_reg[0] ? {1'b0, a_reg} : '0);
  assign prod_next = {mul_sum, prod_reg[WIDTH-1:1]};
  assign bus.busy  = busy_reg;
`else
  assign bus.busy  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      result_reg <= '0;
      flags_reg  <= '0;
      m3_reg     <= '0;
      done_reg   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      prod_reg   <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ev[0]) begin
            a_reg      <= bus.sw;
            result_reg <= bus.sw;
            m3_reg     <= 4'hA;
          end else if (ev[1]) begin
            b_reg      <= bus.sw;
            result_reg <= bus.sw;
            m3_reg     <= 4'hB;
          end else if (ev[2]) begin
            op_reg <= bus.sw[2:0];
            m3_reg <= 4'hC;
`ifdef ALU_SEQ_MUL_EN
            if (bus.sw[2:0] == 3'b111) begin
              state_reg <= MUL;
              busy_reg  <= 1'b1;
              prod_reg  <= {{WIDTH{1'b0}}, b_reg};
              cnt_reg   <= '0;
            end else
`endif
            begin
              result_reg <= op_res;
              flags_reg  <= {op_z, op_n, op_c, op_v};
              done_reg   <= 1'b1;
            end
          end
        end
`ifdef ALU_SEQ_MUL_EN
        MUL: begin
          prod_reg <= prod_next;
          cnt_reg  <= cnt_reg + 6'd1;
          if (cnt_reg == 6'(WIDTH - 1)) begin
            state_reg  <= IDLE;
            busy_reg   <= 1'b0;
            result_reg <= prod_next[WIDTH-1:0];
            flags_reg  <= {prod_next[WIDTH-1:0] == '0, prod_next[WIDTH-1],
                           |prod_next[2*WIDTH-1:WIDTH], 1'b0};
            done_reg   <= 1'b1;
          end
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.result = result_reg;
  assign bus.flags  = flags_reg;
  assign bus.m_3    = m3_reg;
  assign bus.done   = done_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: loads, every opcode, flags, event timing, priority, held buttons, reset.
module tb_alu_seq;

  logic clk;
  logic rst;
  int   total_cnt;
  int   bad_cnt;
  int   busy_cycles;
  int   done_cnt;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.busy) busy_cycles++;
    if (bus.done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: got=%0h", tag, got);
    end
  endtask

  task automatic set_pb(input logic [2:0] mask);
    bus.pb1 = mask[0];
    bus.pb2 = mask[1];
    bus.pb3 = mask[2];
  endtask

  // Two-cycle press, then enough idle cycles for the action to land.
  task automatic press(input logic [2:0] mask, input logic [7:0] val);
    @(negedge clk);
    bus.sw = val;
    set_pb(mask);
    repeat (2) @(negedge clk);
    set_pb(3'b000);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input string tag, input logic [7:0] exp_res, input logic [3:0] exp_flags);
    int d0;
    press(3'b001, a);
    press(3'b010, b);
    d0 = done_cnt;
    press(3'b100, {5'b0, op});
    check({tag, "_res"}, bus.result, exp_res);
    check({tag, "_flags"}, bus.flags, exp_flags);
    check({tag, "_done"}, done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    int b0;
    total_cnt = 0;
    bad_cnt   = 0;
    rst       = 1'b0;
    bus.sw    = '0;
    set_pb(3'b000);
    repeat (3) @(negedge clk);
    check("rst_result", bus.result, 0);
    check("rst_flags", bus.flags, 0);
    check("rst_m3", bus.m_3, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    rst = 1'b1;

    press(3'b001, 8'h7F);
    check("loadA_res", bus.result, 8'h7F);
    check("loadA_m3", bus.m_3, 4'hA);
    press(3'b010, 8'h01);
    check("loadB_res", bus.result, 8'h01);
    check("loadB_m3", bus.m_3, 4'hB);

    // Execute ADD with cycle-exact done timing.
    @(negedge clk);
    bus.sw = 8'h01;
    bus.pb3 = 1'b1;
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.pb3 = 1'b0;
    check("add_done_early", bus.done, 0);
    @(negedge clk);
    check("add_done_k3", bus.done, 1);
    check("add_res", bus.result, 8'h80);
    check("add_flags", bus.flags, 4'b0101);
    check("add_m3", bus.m_3, 4'hC);
    @(negedge clk);
    check("add_done_gone", bus.done, 0);
    repeat (3) @(negedge clk);
    check("add_done_once", done_cnt - d0, 1);

    run_op(8'h05, 8'h06, 3'b010, "sub_borrow", 8'hFF, 4'b0110);
    run_op(8'h22, 8'h22, 3'b010, "sub_zero", 8'h00, 4'b1000);
    run_op(8'hF0, 8'h3C, 3'b100, "and", 8'h30, 4'b0000);
    run_op(8'hF0, 8'h3C, 3'b101, "or", 8'hFC, 4'b0100);
    run_op(8'hF0, 8'h3C, 3'b110, "xor", 8'hCC, 4'b0100);
    run_op(8'hF0, 8'h3C, 3'b011, "not", 8'h0F, 4'b0000);
    run_op(8'hF0, 8'h3C, 3'b000, "op0", 8'h00, 4'b1000);
    run_op(8'hFF, 8'h01, 3'b001, "add_carry", 8'h00, 4'b1010);
    run_op(8'h80, 8'hFF, 3'b001, "add_ovf", 8'h7F, 4'b0011);
    run_op(8'h80, 8'h01, 3'b010, "sub_ovf", 8'h7F, 4'b0001);

    // Held pb1: a second load would pick up the changed switches.
    @(negedge clk);
    bus.sw = 8'h55;
    bus.pb1 = 1'b1;
    repeat (5) @(negedge clk);
    bus.sw = 8'hAA;
    repeat (15) @(negedge clk);
    bus.pb1 = 1'b0;
    repeat (4) @(negedge clk);
    check("held_res", bus.result, 8'h55);
    check("held_m3", bus.m_3, 4'hA);

    // pb1 and pb2 together: only A loads, B keeps 01 from the last run_op.
    press(3'b011, 8'h3C);
    check("prio_res", bus.result, 8'h3C);
    check("prio_m3", bus.m_3, 4'hA);
    d0 = done_cnt;
    press(3'b100, 8'h02);
    check("prio_sub", bus.result, 8'h3B);
    check("prio_flags", bus.flags, 4'b0000);

`ifdef ALU_SEQ_MUL_EN
    press(3'b001, 8'h10);
    press(3'b010, 8'h11);
    b0 = busy_cycles;
    d0 = done_cnt;
    press(3'b100, 8'h07);
    check("mul_busy_on", bus.busy, 1);
    press(3'b001, 8'h99);
    for (int i = 0; i < 50 && bus.busy; i++) @(negedge clk);
    check("mul_timeout", bus.busy, 0);
    repeat (2) @(negedge clk);
    check("mul_busy_len", busy_cycles - b0, 8);
    check("mul_res", bus.result, 8'h10);
    check("mul_flags", bus.flags, 4'b0010);
    check("mul_done", done_cnt - d0, 1);
    check("mul_m3", bus.m_3, 4'hC);
    press(3'b100, 8'h01);
    check("mul_a_held", bus.result, 8'h21);

    // Reset on the third busy cycle aborts the multiply silently.
    press(3'b001, 8'h03);
    press(3'b010, 8'h04);
    @(negedge clk);
    bus.sw = 8'h07;
    bus.pb3 = 1'b1;
    repeat (2) @(negedge clk);
    bus.pb3 = 1'b0;
    for (int i = 0; i < 20 && !bus.busy; i++) @(negedge clk);
    check("rmul_busy_seen", bus.busy, 1);
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rmul_result", bus.result, 0);
    check("rmul_flags", bus.flags, 0);
    check("rmul_m3", bus.m_3, 0);
    check("rmul_busy", bus.busy, 0);
    repeat (12) @(negedge clk);
    check("rmul_no_done", done_cnt - d0, 0);
    run_op(8'h03, 8'h04, 3'b001, "rmul_add", 8'h07, 4'b0000);
`else
    b0 = busy_cycles;
    run_op(8'h10, 8'h11, 3'b111, "op7", 8'h00, 4'b1000);
    check("op7_busy", busy_cycles - b0, 0);

    // Reset clears A, so loading only B and adding returns B.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rst2_result", bus.result, 0);
    check("rst2_m3", bus.m_3, 0);
    press(3'b010, 8'h05);
    press(3'b100, 8'h01);
    check("rst2_add", bus.result, 8'h05);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
